noc_output_allocator: RTL and testbench

Per-output-port switch allocator for the NoC router: arbitrates among the router inputs competing for one output, holds the output for a whole wormhole packet (head to tail), and gates every flit on the downstream credit count. One instance per output port sits between the input flit buffers/route-compute stage and the crossbar select for that output. It runs entirely in the `clk_noc` domain.

---
 rtl/noc_alloc_pkg.sv | 15 +
 rtl/noc_rr_arbiter.sv | 40 ++++
 rtl/noc_output_allocator.sv | 167 ++++++++++++++++
 tb/tb_noc_output_allocator.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_alloc_pkg.sv
// Shared types and constants for the per-output NoC switch allocator.
package noc_alloc_pkg;

    typedef enum logic [0:0] {
        ALLOC_IDLE,
        ALLOC_LOCKED
    } alloc_state_t;

    localparam int unsigned STATS_WIDTH = 32;

    function automatic int unsigned credit_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/noc_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr_i, wrapping to 0.
module noc_rr_arbiter #(
    parameter int unsigned NUM_INPUTS = 5,
    parameter int unsigned IDX_WIDTH  = $clog2(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] req_i,
    input  logic [IDX_WIDTH-1:0]  ptr_i,
    output logic [NUM_INPUTS-1:0] gnt_o,
    output logic [IDX_WIDTH-1:0]  idx_o,
    output logic                  valid_o
);

    logic                 found_hi;
    logic                 found_any;
    logic [IDX_WIDTH-1:0] idx_hi;
    logic [IDX_WIDTH-1:0] idx_any;

    // Scan downwards so the lowest matching index is the one left standing.
    always_comb begin
        found_hi  = 1'b0;
        found_any = 1'b0;
        idx_hi    = '0;
        idx_any   = '0;
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            if (req_i[IDX_WIDTH'(i)]) begin
                found_any = 1'b1;
                idx_any   = IDX_WIDTH'(i);
                if (i >= int'(ptr_i)) begin
                    found_hi = 1'b1;
                    idx_hi   = IDX_WIDTH'(i);
                end
            end
        end
    end

    assign valid_o = found_any;
    assign idx_o   = found_hi ? idx_hi : idx_any;
    assign gnt_o   = found_any ? (NUM_INPUTS'(1) << idx_o) : '0;

endmodule

// File: rtl/noc_output_allocator.sv
// Per-output wormhole switch allocator with round-robin arbitration and credit gating.
// Optional statistics counters are built when NOC_ALLOC_STATS_EN is defined.
module noc_output_allocator
    import noc_alloc_pkg::*;
#(
    parameter int unsigned NUM_INPUTS        = 5,
    parameter int unsigned FLIT_BUFFER_DEPTH = 8,
    parameter int unsigned CREDIT_WIDTH      = credit_width(FLIT_BUFFER_DEPTH),
    parameter int unsigned IDX_WIDTH         = $clog2(NUM_INPUTS)
) (
    input  logic                    clk_noc,
    input  logic                    rst_noc_sync,
    input  logic [NUM_INPUTS-1:0]   req,
    input  logic [NUM_INPUTS-1:0]   req_is_tail,
    input  logic [NUM_INPUTS-1:0]   turn_disable,
    input  logic                    credit_in,
    output logic [NUM_INPUTS-1:0]   grant,
    output logic                    send_out,
    output logic                    locked,
    output logic [IDX_WIDTH-1:0]    owner_idx,
    output logic [CREDIT_WIDTH-1:0] credit_count,
    output logic                    credit_overflow,
    output logic [STATS_WIDTH-1:0]  pkt_count,
    output logic [STATS_WIDTH-1:0]  stall_count
);

    localparam logic [CREDIT_WIDTH-1:0] CreditMax = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);

    alloc_state_t           state_q, state_d;
    logic [IDX_WIDTH-1:0]    owner_q, owner_d;
    logic [IDX_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CREDIT_WIDTH-1:0] credit_q, credit_d;
    logic                    overflow_q, overflow_d;

    logic [NUM_INPUTS-1:0] elig;
    logic [NUM_INPUTS-1:0] arb_gnt;
    logic [IDX_WIDTH-1:0]  arb_idx;
    logic                  arb_valid;
    logic [NUM_INPUTS-1:0] grant_c;
    logic                  has_credit;
    logic                  cred_full;

    function automatic logic [IDX_WIDTH-1:0] next_ptr(input logic [IDX_WIDTH-1:0] idx);
        return (32'(idx) == NUM_INPUTS - 1) ? '0 : idx + 1'b1;
    endfunction

    assign elig       = req & ~turn_disable;
    assign has_credit = credit_q != '0;
    assign cred_full  = credit_q == CreditMax;

    noc_rr_arbiter #(
        .NUM_INPUTS (NUM_INPUTS),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_arb (
        .req_i   (elig),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        grant_c  = '0;
        case (state_q)
            ALLOC_IDLE: begin
                if (arb_valid && has_credit) begin
                    grant_c = arb_gnt;
                    if (req_is_tail[arb_idx]) begin
                        rr_ptr_d = next_ptr(arb_idx);
                    end else begin
                        state_d = ALLOC_LOCKED;
                        owner_d = arb_idx;
                    end
                end
            end
            ALLOC_LOCKED: begin
                // The owner holds the output through bubbles; turn_disable no longer applies.
                if (req[owner_q] && has_credit) begin
                    grant_c = NUM_INPUTS'(1) << owner_q;
                    if (req_is_tail[owner_q]) begin
                        state_d  = ALLOC_IDLE;
                        rr_ptr_d = next_ptr(owner_q);
                    end
                end
            end
            default: state_d = ALLOC_IDLE;
        endcase
    end

    assign grant    = rst_noc_sync ? '0 : grant_c;
    assign send_out = |grant;

    always_comb begin
        credit_d = credit_q;
        if (send_out && !credit_in) begin
            credit_d = credit_q - 1'b1;
        end else if (!send_out && credit_in && !cred_full) begin
            credit_d = credit_q + 1'b1;
        end
    end

    assign overflow_d = overflow_q | (credit_in & cred_full);

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            state_q    <= ALLOC_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            credit_q   <= CreditMax;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            credit_q   <= credit_d;
            overflow_q <= overflow_d;
        end
    end

    assign locked          = state_q == ALLOC_LOCKED;
    assign owner_idx       = owner_q;
    assign credit_count    = credit_q;
    assign credit_overflow = overflow_q;

`ifdef NOC_ALLOC_STATS_EN
    logic [STATS_WIDTH-1:0] pkt_q, pkt_d;
    logic [STATS_WIDTH-1:0] stall_q, stall_d;
    logic                   tail_sent;
    logic                   stall_cyc;

    assign tail_sent = |(grant & req_is_tail);
    assign stall_cyc = !has_credit &&
                       ((state_q == ALLOC_LOCKED && req[owner_q]) ||
                        (state_q == ALLOC_IDLE && |elig));

    always_comb begin
        pkt_d   = pkt_q;
        stall_d = stall_q;
        if (tail_sent && pkt_q != '1) begin
            pkt_d = pkt_q + 1'b1;
        end
        if (stall_cyc && stall_q != '1) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            pkt_q   <= '0;
            stall_q <= '0;
        end else begin
            pkt_q   <= pkt_d;
            stall_q <= stall_d;
        end
    end

    assign pkt_count   = pkt_q;
    assign stall_count = stall_q;
`else
    assign pkt_count   = '0;
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_noc_output_allocator.sv
// Scoreboard bench for noc_output_allocator: a queue-based reference model predicts each cycle.
module tb_noc_output_allocator;

    localparam int N     = 5;
    localparam int IW    = 3;
    localparam int DEPTH = 8;
`ifdef NOC_ALLOC_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic          clk_noc = 1'b0;
    logic          rst_noc_sync = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  req_is_tail = '0;
    logic [N-1:0]  turn_disable = '0;
    logic          credit_in = 1'b0;
    logic [N-1:0]  grant;
    logic          send_out;
    logic          locked;
    logic [IW-1:0] owner_idx;
    logic [3:0]    credit_count;
    logic          credit_overflow;
    logic [31:0]   pkt_count;
    logic [31:0]   stall_count;

    noc_output_allocator dut (
        .clk_noc         (clk_noc),
        .rst_noc_sync    (rst_noc_sync),
        .req             (req),
        .req_is_tail     (req_is_tail),
        .turn_disable    (turn_disable),
        .credit_in       (credit_in),
        .grant           (grant),
        .send_out        (send_out),
        .locked          (locked),
        .owner_idx       (owner_idx),
        .credit_count    (credit_count),
        .credit_overflow (credit_overflow),
        .pkt_count       (pkt_count),
        .stall_count     (stall_count)
    );

    always #5 clk_noc = ~clk_noc;

    typedef struct {
        logic [N-1:0] grant;
        int           cred;
        bit           locked;
        int           owner;
        bit           ovf;
        int           pkt;
        int           stall;
    } exp_t;

    exp_t         exp_q[$];
    logic [N-1:0] flit_q[$];

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: owner < 0 means the output is free.
    int m_owner = -1;
    int m_rr    = 0;
    int m_cred  = DEPTH;
    bit m_ovf   = 1'b0;
    int m_pkt   = 0;
    int m_stall = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] t, input logic [N-1:0] d,
                        input logic c, input logic rs);
        exp_t         e;
        int           g;
        logic [N-1:0] el;
        @(posedge clk_noc);
        #1;
        req          = r;
        req_is_tail  = t;
        turn_disable = d;
        credit_in    = c;
        rst_noc_sync = rs;

        e.cred   = m_cred;
        e.locked = m_owner >= 0;
        e.owner  = m_owner;
        e.ovf    = m_ovf;
        e.pkt    = m_pkt;
        e.stall  = m_stall;
        g        = -1;

        if (rs) begin
            m_owner = -1;
            m_rr    = 0;
            m_cred  = DEPTH;
            m_ovf   = 1'b0;
            m_pkt   = 0;
            m_stall = 0;
        end else begin
            el = r & ~d;
            if (m_owner < 0) begin
                if (el != '0) begin
                    if (m_cred > 0) begin
                        for (int k = 0; k < N; k++) begin
                            int cand;
                            cand = (m_rr + k) % N;
                            if (g < 0 && el[IW'(cand)]) g = cand;
                        end
                        if (t[IW'(g)]) begin
                            m_rr = (g + 1) % N;
                            if (STATS_EN) m_pkt++;
                        end else begin
                            m_owner = g;
                        end
                    end else if (STATS_EN) begin
                        m_stall++;
                    end
                end
            end else if (r[IW'(m_owner)]) begin
                if (m_cred > 0) begin
                    g = m_owner;
                    if (t[IW'(g)]) begin
                        m_owner = -1;
                        m_rr    = (g + 1) % N;
                        if (STATS_EN) m_pkt++;
                    end
                end else if (STATS_EN) begin
                    m_stall++;
                end
            end
            if (c && m_cred == DEPTH) m_ovf = 1'b1;
            m_cred = m_cred - ((g >= 0) ? 1 : 0) + (c ? 1 : 0);
            if (m_cred > DEPTH) m_cred = DEPTH;
        end

        e.grant = (g >= 0) ? N'(32'd1 << g) : '0;
        exp_q.push_back(e);
        if (g >= 0) flit_q.push_back(e.grant);
    endtask

    // Monitor: per-cycle status from exp_q, per-flit grant from flit_q whenever send_out fires.
    initial begin
        exp_t         e;
        logic [N-1:0] fg;
        forever begin
            @(negedge clk_noc);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("grant", 32'(grant), 32'(e.grant));
                check("send_out", 32'(send_out), 32'(e.grant != '0));
                check("credit_count", 32'(credit_count), 32'(e.cred));
                check("locked", 32'(locked), 32'(e.locked));
                if (e.locked) check("owner_idx", 32'(owner_idx), 32'(e.owner));
                check("credit_overflow", 32'(credit_overflow), 32'(e.ovf));
                check("pkt_count", pkt_count, 32'(e.pkt));
                check("stall_count", stall_count, 32'(e.stall));
            end
            if (send_out === 1'b1) begin
                n_total++;
                if (flit_q.size() == 0) begin
                    $display("FAIL flit: send_out=1 with grant %b, expected no flit", grant);
                end else begin
                    fg = flit_q.pop_front();
                    if (grant === fg) n_pass++;
                    else $display("FAIL flit: grant %b, expected %b", grant, fg);
                end
            end
        end
    end

    initial begin
        int cin_pct;
        logic [N-1:0] td;
        repeat (2) @(posedge clk_noc);

        // Post-reset idle, then a single-flit packet from input 2.
        step('0, '0, '0, 1'b0, 1'b1);
        step('0, '0, '0, 1'b0, 1'b0);
        step(5'b00100, 5'b00100, '0, 1'b0, 1'b0);
        step('0, '0, '0, 1'b0, 1'b0);
        // Next arbitration should start at input 3.
        step(5'b01001, 5'b01001, '0, 1'b0, 1'b0);

        // Wormhole: input 1 sends 4 flits while input 3 keeps requesting.
        step('0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(5'b01010, (i == 3) ? 5'b01010 : 5'b01000, '0, 1'b0, 1'b0);
        step(5'b01000, 5'b01000, '0, 1'b0, 1'b0);
        step('0, '0, '0, 1'b0, 1'b0);

        // Credit stall on a long packet from input 0.
        step('0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(5'b00001, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(5'b00001, '0, '0, 1'b0, 1'b0);
        step(5'b00001, '0, '0, 1'b1, 1'b0);
        step(5'b00001, '0, '0, 1'b0, 1'b0);
        step(5'b00001, '0, '0, 1'b0, 1'b0);
        step(5'b00001, 5'b00001, '0, 1'b1, 1'b0);
        step(5'b00001, 5'b00001, '0, 1'b0, 1'b0);
        step('0, '0, '0, 1'b0, 1'b0);

        // Round-robin fairness, then with input 1 turn-disabled.
        step('0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(5'b11111, 5'b11111, '0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(5'b11111, 5'b11111, 5'b00010, 1'b1, 1'b0);

        // Simultaneous send and credit return at 3 credits.
        step('0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(5'b00001, 5'b00001, '0, 1'b0, 1'b0);
        step(5'b00001, 5'b00001, '0, 1'b1, 1'b0);
        step('0, '0, '0, 1'b0, 1'b0);

        // Credit return while full.
        step('0, '0, '0, 1'b0, 1'b1);
        step('0, '0, '0, 1'b1, 1'b0);
        step('0, '0, '0, 1'b0, 1'b0);

        // Reset mid-packet.
        step('0, '0, '0, 1'b0, 1'b1);
        step(5'b00100, '0, '0, 1'b0, 1'b0);
        step(5'b00100, '0, '0, 1'b0, 1'b0);
        step(5'b00100, '0, '0, 1'b0, 1'b1);
        step(5'b00100, '0, '0, 1'b0, 1'b1);
        step('0, '0, '0, 1'b0, 1'b0);

        // Randomised traffic in segments with quasi-static turn_disable and varying credit rate.
        for (int seg = 0; seg < 6; seg++) begin
            td      = (seg % 3 == 2) ? N'($urandom & $urandom & $urandom) : '0;
            cin_pct = (seg % 2 == 0) ? 35 : 75;
            step('0, '0, td, 1'b0, 1'b1);
            for (int i = 0; i < 500; i++) begin
                step(N'($urandom), N'($urandom & $urandom), td,
                     $urandom_range(0, 99) < cin_pct, $urandom_range(0, 299) == 0);
            end
        end
        step('0, '0, '0, 1'b0, 1'b0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk_noc);
        @(negedge clk_noc);
        #1;
        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        check("flit_queue_drained", 32'(flit_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
